bus_reg_universal: RTL

//  Parametrised successor to the 4-bit SAP-1 bus register: WIDTH-bit register with tri-state bus drive,

---
 rtl/bus_reg_universal_pkg.sv | 15 +
 rtl/bus_reg_universal_next.sv | 84 ++++++++
 rtl/bus_reg_universal.sv | 58 +++++
 3 files changed

// File: rtl/bus_reg_universal_pkg.sv
// Shared operation codes for the universal bus register and the control sequencer that drives it.
package bus_reg_universal_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_INC  = 3'b010,
    MODE_DEC  = 3'b011,
    MODE_SHL  = 3'b100,
    MODE_SHR  = 3'b101,
    MODE_ROL  = 3'b110,
    MODE_ROR  = 3'b111
  } mode_e;

endpackage

// File: rtl/bus_reg_universal_next.sv
// Next-state logic for the universal bus register: clear/load/count/shift/rotate mux plus terminal count.
module bus_reg_universal_next
  import bus_reg_universal_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             clr_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             co_i,
  output logic [WIDTH-1:0] q_d_o,
  output logic             co_d_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_e mode;
  assign mode = mode_e'(mode_i);

  always_comb begin
    q_d_o  = q_i;
    co_d_o = co_i;
    if (clr_i) begin
      q_d_o  = RESET_VAL;
      co_d_o = 1'b0;
    end else begin
      case (mode)
        MODE_LOAD: begin
          q_d_o  = d_i;
          co_d_o = 1'b0;
        end
        // co flags the wrap event in both wrapping and saturating builds
        MODE_INC: begin
          if (q_i == ONES) begin
            q_d_o  = SATURATE ? ONES : '0;
            co_d_o = 1'b1;
          end else begin
            q_d_o  = q_i + ONE;
            co_d_o = 1'b0;
          end
        end
        MODE_DEC: begin
          if (q_i == '0) begin
            q_d_o  = SATURATE ? '0 : ONES;
            co_d_o = 1'b1;
          end else begin
            q_d_o  = q_i - ONE;
            co_d_o = 1'b0;
          end
        end
        MODE_SHL: begin
          q_d_o  = {q_i[WIDTH-2:0], sin_i};
          co_d_o = q_i[WIDTH-1];
        end
        MODE_SHR: begin
          q_d_o  = {sin_i, q_i[WIDTH-1:1]};
          co_d_o = q_i[0];
        end
        MODE_ROL: begin
          q_d_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
          co_d_o = q_i[WIDTH-1];
        end
        MODE_ROR: begin
          q_d_o  = {q_i[0], q_i[WIDTH-1:1]};
          co_d_o = q_i[0];
        end
        default: begin
          q_d_o  = q_i;
          co_d_o = co_i;
        end
      endcase
    end
  end

  assign tc_o = ((mode == MODE_INC) && (q_i == ONES)) ||
                ((mode == MODE_DEC) && (q_i == '0));

endmodule

// File: rtl/bus_reg_universal.sv
// WIDTH-bit SAP-1 bus register with load/count/shift/rotate modes, flags and tri-state W-bus drive.
module bus_reg_universal
  import bus_reg_universal_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             e_saida,
  output logic [WIDTH-1:0] q_bus,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             tc,
  output logic             co
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;

  bus_reg_universal_next #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .clr_i (clr),
    .mode_i(mode),
    .d_i   (d),
    .sin_i (sin),
    .q_i   (q_q),
    .co_i  (co_q),
    .q_d_o (q_d),
    .co_d_o(co_d),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q  <= RESET_VAL;
      co_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end

  assign q     = q_q;
  assign co    = co_q;
  assign zero  = (q_q == '0);
  // Bus release is independent of the clock so the sequencer can hand the W-bus over mid-cycle
  assign q_bus = e_saida ? q_q : {WIDTH{1'bz}};

endmodule
